irq_req_capture: RTL
====================

# irq_req_capture

Request-capture front end for the 8-input priority encoder. It synchronises eight asynchronous request lines, detects rising edges and holds each event in a pending register whose bits drive the encoder's 8-bit input. It arbitrates one pending request at a time, highest index first, and presents the request to a consumer over a valid/ack handshake. The serviced bit is cleared on acknowledge, and events that arrive while a bit is already pending are flagged as overruns.

## Interface
Parameters:
- none; the width is fixed at 8 requests with a 3-bit id.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  capture enable; 0 blocks new edges and new grants
- req_in  in  8  asynchronous request lines, edge-triggered on rising edge
- mask  in  8  1 = request eligible for grant; the bit still latches when 0
- irq_ack  in  1  consumer accepts the presented request
- ovr_clr  in  1  one-cycle pulse that clears the whole overrun vector
- pend_out  out  8  pending register; connects to the priority encoder's 8-bit input
- irq_valid  out  1  a granted request is being presented
- irq_id  out  3  index of the granted request, 7 = highest priority
- overrun  out  8  sticky; set when an edge arrives on an already-pending bit

## Operation
- Input path: req_in passes through the synchroniser (see Configuration) to give s_q, then a history register p_q.
- Edge detect: edge = s_q & ~p_q.
- Pending set: pend[i] is set when en=1 and edge[i]=1.
- Pending clear: pend[irq_id] clears on the accepting cycle. If a new edge on the same bit arrives in the same cycle, set wins and the bit stays 1.
- Overrun: overrun[i] is set when en=1, edge[i]=1 and pend[i] is already 1 (acks in that cycle are ignored for this check).
- Overrun clear: ovr_clr clears the vector. A set in the same cycle wins.
- Eligibility: elig = pend & mask.
- FSM, IDLE:
  - If en=1 and elig≠0, latch irq_id = highest set index of elig and go to GRANT.
  - Otherwise stay in IDLE.
- FSM, GRANT:
  - irq_valid=1; irq_id is held stable.
  - If irq_ack=1, clear pend[irq_id] and go to CLEAR.
  - mask and en changes do not withdraw the grant.
- FSM, CLEAR:
  - irq_valid=0; unconditional return to IDLE.
  - This gives one bubble cycle so that pend_out settles before re-arbitration.
- irq_ack outside GRANT is ignored.
- A second ack while in CLEAR has no effect.
- Illegal FSM encodings recover to IDLE.

## Timing
- Reset values (asserted asynchronously):
  - pend_out=0, overrun=0, irq_valid=0, irq_id=0, FSM=IDLE.
  - Synchroniser and history registers = 0.
- A line held high through reset release therefore produces exactly one pending event.
- Latency is counted from the first rising edge at which req_in is sampled high, called edge E1:
  - With IRQ_SYNC_EN: pend bit visible after E3, irq_valid after E4.
  - Without IRQ_SYNC_EN: pend bit visible after E2, irq_valid after E3.
- Ack latency:
  - Ack sampled at edge A: irq_valid=0 and the pend bit clears after A.
  - The next grant can appear no earlier than after A+2.
- Minimum request pulse is one clk period high, plus one low period between events on the same line.
- Reset mid-grant: all state clears immediately. A pending ack is lost and no grant survives.

## Configuration
- IRQ_SYNC_EN defined:
  - Two flop synchroniser per line; s_q is the second flop.
  - Latencies are as stated with IRQ_SYNC_EN above.
- IRQ_SYNC_EN undefined:
  - Single flop capture; s_q is that flop. Use only when req_in is already synchronous to clk.
  - Latency is one cycle shorter.
- No other behaviour changes.

## Test plan
- Reset with req_in=8'hFF held, release rst_n, en=1, mask=8'hFF -> pend_out=8'hFF after three edges (sync); irq_id=7 granted first; acking in turn yields ids 7,6,5…0, each grant separated by one idle cycle.
- Pulse req_in[2] and req_in[5] on the same edge, mask=8'h04 -> pend_out=8'h24; only id 2 is granted; after ack pend_out=8'h20 and irq_valid stays 0 until mask[5] is set.
- Hold a grant on id 3, then pulse req_in[3] again -> overrun=8'h08; ack together with ovr_clr -> pend_out[3] cleared, overrun=0.
- New edge on bit 4 in the same cycle as the ack of id 4 -> pend_out[4] remains 1, overrun[4]=1, and id 4 is granted again after the bubble.
- en=0 with pulses on all lines -> pend_out is unchanged and no new grant appears; an existing grant still completes on ack.
- Assert rst_n=0 mid-GRANT -> irq_valid, pend_out and overrun are 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/irq_req_capture_if.sv
// irq_req_capture_if
//   Request/acknowledge handshake between the capture front end (master)
//   and the interrupt consumer (slave).
//   irq_valid : master -> slave, a granted request is being presented
//   irq_id    : master -> slave, index of the granted request (7 = highest)
//   irq_ack   : slave -> master, consumer accepts the presented request
interface irq_req_capture_if;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ack;

  modport master (output irq_valid, output irq_id, input irq_ack);
  modport slave  (input irq_valid, input irq_id, output irq_ack);
endinterface

// File: rtl/irq_req_capture.sv
// irq_req_capture
//   Captures rising edges on eight asynchronous request lines into a pending
//   register (which feeds the 8-input priority encoder), arbitrates one
//   pending and unmasked request at a time (highest index first) and presents
//   it over a valid/ack handshake. Edges on an already-pending bit set a
//   sticky overrun flag.
//
//   Ports:
//     clk      in   system clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     en       in   capture enable; 0 blocks new edges and new grants
//     req_in   in   [7:0] asynchronous request lines
//     mask     in   [7:0] 1 = eligible for grant (latching is unaffected)
//     ovr_clr  in   clears the overrun vector
//     pend_out out  [7:0] pending register
//     overrun  out  [7:0] sticky overrun flags
//     irq      master modport of irq_req_capture_if (irq_valid/irq_id/irq_ack)
//
//   Build option: define IRQ_SYNC_EN for a two-flop synchroniser on req_in;
//   otherwise a single capture flop is used (req_in must then already be
//   synchronous to clk) and all request latencies are one cycle shorter.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant; arbitrate eligible pending bits when en=1
//   GRANT | irq_valid=1, irq_id held; waiting for irq_ack
//   CLEAR | one bubble cycle so pend_out settles before re-arbitration
module irq_req_capture (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [7:0]                req_in,
  input  logic [7:0]                mask,
  input  logic                      ovr_clr,
  output logic [7:0]                pend_out,
  output logic [7:0]                overrun,
  irq_req_capture_if.master         irq
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GRANT = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;

  logic [1:0] state;
  logic [2:0] id_q;
  logic [7:0] s_q;
  logic [7:0] p_q;
  logic [7:0] pend_q;
  logic [7:0] ovr_q;
  logic [7:0] edge_det;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] elig;
  logic       ack_fire;

`ifdef IRQ_SYNC_EN
  logic [7:0] s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s_q  <= '0;
    end else begin
      s1_q <= req_in;
      s_q  <= s1_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= req_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_q <= '0;
    else        p_q <= s_q;
  end

  function automatic logic [2:0] hi_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = i[2:0];
    end
    return r;
  endfunction

  assign edge_det = s_q & ~p_q;
  assign set_vec  = en ? edge_det : 8'h00;
  assign ack_fire = (state == GRANT) && irq.irq_ack;
  assign clr_vec  = ack_fire ? (8'b1 << id_q) : 8'h00;
  assign elig     = pend_q & mask;

  // Set is applied after clear so a new edge on the bit being acked survives;
  // the overrun check looks at pending before this cycle's ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_vec) | set_vec;
      ovr_q  <= (ovr_clr ? 8'h00 : ovr_q) | (set_vec & pend_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      id_q  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (elig != 8'h00)) begin
            id_q  <= hi_idx(elig);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (irq.irq_ack) state <= CLEAR;
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pend_out      = pend_q;
  assign overrun       = ovr_q;
  assign irq.irq_valid = (state == GRANT);
  assign irq.irq_id    = id_q;

endmodule
